// File: rtl/sd_block_reader.sv
// sd_block_reader
//   Multi-block SD read sequencer. Drives the SD helper's setAddr/addr/ren
//   strobes one sector at a time and captures the returned words into an
//   output FIFO that is drained over a valid/ready handshake. A read strobe is
//   only issued when the FIFO is guaranteed to have room for the word.
//
//   Optional feature macro: SD_READER_CSUM_EN adds a running XOR checksum
//   output (csum) over every word captured for the current request.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only when idle)
//   req_sector, req_nblocks        first sector and sector count (0 legal)
//   sd_setAddr, sd_addr, sd_ren    helper controls (all registered)
//   sd_data                        helper data, sampled at the end of a ren cycle
//   out_valid/out_ready            output stream handshake
//   out_data, out_last             FIFO head word, last-word-of-sector flag
//   busy, done                     not-idle flag, one-cycle completion pulse
//   csum                           (SD_READER_CSUM_EN only) XOR of captured words
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// SETA  | setAddr pulse with the current sector number
// GAP   | one idle cycle between setAddr and the first ren
// READ  | issue ren whenever the FIFO has room, count captured words
// DRAIN | all words captured, waiting for the FIFO to empty
// DONE  | request finished; done pulses in the following cycle

module sd_block_reader #(
  parameter int WORDS_PER_BLK = 128,
  parameter int FIFO_DEPTH    = 16,
  parameter int NBLK_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_sector,
  input  logic [NBLK_W-1:0] req_nblocks,
  output logic              sd_setAddr,
  output logic [31:0]       sd_addr,
  output logic              sd_ren,
  input  logic [31:0]       sd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef SD_READER_CSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WCW = $clog2(WORDS_PER_BLK + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETA, S_GAP, S_READ, S_DRAIN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       sector_q, sector_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  logic [NBLK_W-1:0] blk_q, blk_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;   // words captured in this sector
  logic [WCW-1:0]    rcnt_q, rcnt_d;   // ren strobes issued in this sector
  logic              setaddr_q, setaddr_d;
  logic [31:0]       addr_q, addr_d;
  logic              ren_q, ren_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       csum_q, csum_d;

  // Output FIFO: a registered head word plus a circular buffer behind it.
  // cnt_q counts the head plus buffered words, so it never exceeds FIFO_DEPTH.
  logic [32:0]       mem [FIFO_DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic              head_v_q, head_v_d;
  logic [31:0]       head_data_q, head_data_d;
  logic              head_last_q, head_last_d;

  logic              push, pop, push_last, head_free, mem_we;
  logic [CW-1:0]     buf_cnt, occ_next;

  assign push_last = (wcnt_q == WCW'(WORDS_PER_BLK - 1));

  always_comb begin
    push        = ren_q;
    pop         = head_v_q && out_ready;
    head_free   = !head_v_q || pop;
    buf_cnt     = cnt_q - CW'(head_v_q);
    occ_next    = cnt_q + CW'(push) - CW'(pop);
    head_v_d    = head_v_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    mem_we      = 1'b0;
    if (head_free) begin
      if (buf_cnt != '0) begin
        head_v_d                   = 1'b1;
        {head_last_d, head_data_d} = mem[rd_q];
        rd_d                       = rd_q + 1'b1;
      end else if (push) begin
        head_v_d    = 1'b1;
        head_data_d = sd_data;
        head_last_d = push_last;
      end else begin
        head_v_d    = 1'b0;
      end
    end
    // A pushed word bypasses the buffer only when the head is free and
    // nothing older is waiting.
    if (push && !(head_free && buf_cnt == '0)) begin
      mem_we = 1'b1;
      wr_d   = wr_q + 1'b1;
    end
    cnt_d = occ_next;
  end

  always_comb begin
    state_d   = state_q;
    sector_d  = sector_q;
    nblk_d    = nblk_q;
    blk_d     = blk_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    setaddr_d = 1'b0;
    addr_d    = addr_q;
    ren_d     = 1'b0;
    done_d    = (state_q == S_DONE);
    csum_d    = csum_q;
    if (push) csum_d = csum_q ^ sd_data;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          sector_d = req_sector;
          nblk_d   = req_nblocks;
          blk_d    = '0;
          csum_d   = '0;
          if (req_nblocks == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_SETA;
            setaddr_d = 1'b1;
            addr_d    = req_sector;
            wcnt_d    = '0;
            rcnt_d    = '0;
          end
        end
      end
      S_SETA: state_d = S_GAP;
      S_GAP: begin
        state_d = S_READ;
        if (occ_next < CW'(FIFO_DEPTH)) begin
          ren_d  = 1'b1;
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (push) wcnt_d = wcnt_q + 1'b1;
        if (push && push_last) begin
          blk_d = blk_q + 1'b1;
          if (({1'b0, blk_q} + 1'b1) < {1'b0, nblk_q}) begin
            state_d   = S_SETA;
            setaddr_d = 1'b1;
            addr_d    = sector_q + 32'(blk_q) + 32'd1;
            wcnt_d    = '0;
            rcnt_d    = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (rcnt_q < WCW'(WORDS_PER_BLK) && occ_next < CW'(FIFO_DEPTH)) begin
          // Room is judged on the occupancy after this edge, without counting
          // on a pop in the ren cycle itself.
          ren_d  = 1'b1;
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_DRAIN: if (occ_next == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sector_q    <= '0;
      nblk_q      <= '0;
      blk_q       <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      setaddr_q   <= 1'b0;
      addr_q      <= '0;
      ren_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      csum_q      <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      head_v_q    <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sector_q    <= sector_d;
      nblk_q      <= nblk_d;
      blk_q       <= blk_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      setaddr_q   <= setaddr_d;
      addr_q      <= addr_d;
      ren_q       <= ren_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      head_v_q    <= head_v_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_q] <= {push_last, sd_data};
  end

  assign req_ready  = req_ready_q;
  assign sd_setAddr = setaddr_q;
  assign sd_addr    = addr_q;
  assign sd_ren     = ren_q;
  assign out_valid  = head_v_q;
  assign out_data   = head_data_q;
  assign out_last   = head_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SD_READER_CSUM_EN
  assign csum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_sd_block_reader.sv
module tb_sd_block_reader;
  localparam int W = 128;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_sector = '0;
  logic [7:0]  req_nblocks = '0;
  logic        sd_setAddr;
  logic [31:0] sd_addr;
  logic        sd_ren;
  logic [31:0] sd_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef SD_READER_CSUM_EN
  logic [31:0] csum;
`endif

  sd_block_reader #(.WORDS_PER_BLK(W), .FIFO_DEPTH(D), .NBLK_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sector(req_sector), .req_nblocks(req_nblocks),
    .sd_setAddr(sd_setAddr), .sd_addr(sd_addr), .sd_ren(sd_ren), .sd_data(sd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef SD_READER_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // SD helper model: setAddr restarts the word index of a sector, each ren
  // cycle consumes one word. Data is either {sector[15:0], index} or index.
  bit          pat_idx = 1'b0;
  logic [31:0] h_addr = '0;
  logic [31:0] h_idx = '0;
  always @(posedge clk) begin
    if (sd_setAddr) begin
      h_addr <= sd_addr;
      h_idx  <= '0;
    end else if (sd_ren) begin
      h_idx <= h_idx + 1;
    end
  end
  always_comb sd_data = pat_idx ? h_idx : {h_addr[15:0], h_idx[15:0]};

  function automatic logic [31:0] pat(input logic [31:0] a, input int i);
    return pat_idx ? 32'(i) : {a[15:0], 16'(i)};
  endfunction

  typedef struct packed {logic [31:0] d; logic l;} word_t;
  word_t       exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] seen_addr[$];
  int          last_pos[$];
  logic [31:0] exp_csum;
  word_t       e;

  int tcnt = 0;
  always @(posedge clk) tcnt <= tcnt + 1;

  int n_seta, n_ren, n_words, n_last, n_done;
  int first_valid_t, done_t, acc;
  logic        done_rr;
  logic [31:0] first_word, last_word, csum_at_done;
  int   occ = 0;
  logic prev_ren = 0, prev_pop = 0, prev_seta = 0, prev_v = 0, prev_r = 0, prev_l = 0;
  logic [31:0] prev_d = '0;

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      occ = occ + (prev_ren ? 1 : 0) - (prev_pop ? 1 : 0);
      chk("valid_vs_occupancy", 64'(out_valid), 64'(occ > 0));
      chk("occupancy_bound", 64'(occ <= D), 64'd1);
      chk("ren_after_seta", 64'(sd_ren && (sd_setAddr || prev_seta)), 64'd0);
      if (prev_v && !prev_r)
        chk("head_hold", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, prev_l, prev_d});
      if (sd_setAddr) begin
        n_seta++;
        seen_addr.push_back(sd_addr);
        if (exp_addr_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL seta_extra: got addr %0h want no setAddr", sd_addr);
        end else chk("seta_addr", 64'(sd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (sd_ren) n_ren++;
      if (out_valid && first_valid_t < 0) first_valid_t = tcnt;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL word_extra: got %0h want no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 64'(out_data), 64'(e.d));
          chk("word_last", 64'(out_last), 64'(e.l));
        end
        if (n_words == 0) first_word = out_data;
        last_word = out_data;
        n_words++;
        if (out_last) last_pos.push_back(n_words);
      end
      if (done) begin
        n_done++;
        done_t  = tcnt;
        done_rr = req_ready;
`ifdef SD_READER_CSUM_EN
        csum_at_done = csum;
`endif
      end
      prev_ren  = sd_ren;
      prev_pop  = out_valid && out_ready;
      prev_seta = sd_setAddr;
      prev_v    = out_valid;
      prev_r    = out_ready;
      prev_l    = out_last;
      prev_d    = out_data;
    end
  end

  task automatic do_req(input logic [31:0] sec, input int n);
    logic [31:0] a, w;
    exp_csum = '0;
    for (int b = 0; b < n; b++) begin
      a = sec + 32'(b);
      exp_addr_q.push_back(a);
      for (int i = 0; i < W; i++) begin
        w = pat(a, i);
        exp_q.push_back(word_t'{w, (i == W - 1)});
        exp_csum ^= w;
      end
    end
    n_seta = 0; n_ren = 0; n_words = 0; n_last = 0; n_done = 0;
    first_valid_t = -1; done_t = -1;
    seen_addr.delete(); last_pos.delete();
    req_sector = sec; req_nblocks = 8'(n); req_valid = 1'b1;
    @(posedge clk); #1;
    acc = tcnt;
    req_valid = 1'b0;
  endtask

  task automatic finish_req(input string tag, input int n);
    int k = 0;
    while (n_done == 0 && k < 400 * (n + 1)) begin
      @(posedge clk); #1; k++;
    end
    if (n_done == 0) begin
      vecs++; errs++;
      $display("FAIL %s_done_timeout: got no done after %0d cycles want done", tag, k);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_words"}, 64'(n_words), 64'(W * n));
    chk({tag, "_ren"}, 64'(n_ren), 64'(W * n));
    chk({tag, "_seta"}, 64'(n_seta), 64'(n));
    chk({tag, "_lasts"}, 64'(last_pos.size()), 64'(n));
    chk({tag, "_done_cnt"}, 64'(n_done), 64'd1);
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_ready_at_done"}, 64'(done_rr), 64'd1);
`ifdef SD_READER_CSUM_EN
    chk({tag, "_csum"}, 64'(csum_at_done), 64'(exp_csum));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_outs", {58'd0, out_valid, busy, done, sd_ren, sd_setAddr, out_last}, 64'd0);
    chk("rst_addr_data", {sd_addr, out_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single sector
    do_req(32'd5, 1);
    finish_req("t1", 1);
    chk("t1_latency", 64'(first_valid_t - acc + 1), 64'd4);
    chk("t1_first_word", 64'(first_word), 64'h0005_0000);
    chk("t1_last_word", 64'(last_word), 64'h0005_007F);

    // three sectors wrapping the sector number
    do_req(32'hFFFF_FFFF, 3);
    finish_req("t2", 3);
    if (seen_addr.size() == 3) begin
      chk("t2_addr0", 64'(seen_addr[0]), 64'hFFFF_FFFF);
      chk("t2_addr1", 64'(seen_addr[1]), 64'h0);
      chk("t2_addr2", 64'(seen_addr[2]), 64'h1);
    end
    if (last_pos.size() == 3) begin
      chk("t2_last_pos0", 64'(last_pos[0]), 64'd128);
      chk("t2_last_pos1", 64'(last_pos[1]), 64'd256);
      chk("t2_last_pos2", 64'(last_pos[2]), 64'd384);
    end

    // consumer stall mid-sector
    do_req(32'h10, 1);
    k = 0;
    while (n_words < 40 && k < 200) begin @(posedge clk); #1; k++; end
    out_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("t3_in_fifo", 64'(n_ren - n_words), 64'd16);
    chk("t3_ren_low", 64'(sd_ren), 64'd0);
    out_ready = 1'b1;
    finish_req("t3", 1);

    // zero-length request
    do_req(32'h40, 0);
    finish_req("t4", 0);
    chk("t4_done_latency", 64'(done_t - acc + 1), 64'd2);

    // reset in the middle of sector 2
    do_req(32'd100, 3);
    k = 0;
    while (n_words < W + 60 && k < 600) begin @(posedge clk); #1; k++; end
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req_ready", 64'(req_ready), 64'd1);
    chk("t5_rst_outs", {58'd0, out_valid, busy, done, sd_ren, sd_setAddr, out_last}, 64'd0);
    chk("t5_rst_addr_data", {sd_addr, out_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_done", 64'(n_done), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    occ = 0; prev_ren = 0; prev_pop = 0; prev_seta = 0; prev_v = 0; prev_r = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(32'd7, 1);
    finish_req("t5b", 1);

`ifdef SD_READER_CSUM_EN
    // index-valued data: XOR of 0..127 is zero
    pat_idx = 1'b1;
    do_req(32'd9, 1);
    finish_req("t6", 1);
    chk("t6_csum_idx", 64'(csum_at_done), 64'd0);
    pat_idx = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
